// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcodes, instruction format enum and opcode-to-format lookup.
// Rev 1.0
`default_nettype none

package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_t;

  function automatic fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_R:                                  return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   return FMT_I;
      OP_STORE:                              return FMT_S;
      OP_BRANCH:                             return FMT_B;
      OP_LUI, OP_AUIPC:                      return FMT_U;
      OP_JAL:                                return FMT_J;
      default:                               return FMT_BAD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: places a 32-bit immediate into its RV32I bit positions and flags range errors.
// Rev 1.0
`default_nettype none

module imm_pack
  import rv32_pkg::*;
(
  input  fmt_t        fmt,
  input  logic [31:0] imm,
  input  logic        shift,
  output logic [31:0] placed,
  output logic        err
);

  logic fits12, fits13, fits21;

  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}});
  assign fits21 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    placed = 32'b0;
    err    = 1'b0;
    case (fmt)
      FMT_I: begin
        if (shift) begin
          // shamt is unsigned: any negative value is out of range too
          placed[24:20] = imm[4:0];
          err           = |imm[31:5];
        end else begin
          placed[31:20] = imm[11:0];
          err           = !fits12;
        end
      end
      FMT_S: begin
        placed[31:25] = imm[11:5];
        placed[11:7]  = imm[4:0];
        err           = !fits12;
      end
      FMT_B: begin
        placed[31]    = imm[12];
        placed[30:25] = imm[10:5];
        placed[11:8]  = imm[4:1];
        placed[7]     = imm[11];
        err           = !fits13 || imm[0];
      end
      FMT_U: begin
        placed[31:12] = imm[31:12];
        err           = |imm[11:0];
      end
      FMT_J: begin
        placed[31]    = imm[20];
        placed[30:21] = imm[10:1];
        placed[20]    = imm[11];
        placed[19:12] = imm[19:12];
        err           = !fits21 || imm[0];
      end
      default: begin
        placed = 32'b0;
        err    = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// instr_encoder: 2-stage valid/ready RV32I field-to-word encoder with word address tagging.
// Rev 1.0
`default_nettype none

module instr_encoder
  import rv32_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClear,
  input  logic              iValid,
  output logic              oReady,
  input  logic [6:0]        iOpcode,
  input  logic [4:0]        iRd,
  input  logic [2:0]        iFunct3,
  input  logic [4:0]        iRs1,
  input  logic [4:0]        iRs2,
  input  logic [6:0]        iFunct7,
  input  logic [31:0]       iImm,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oInstr,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oErr,
  output logic [7:0]        oErrCnt
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  logic              s1_valid, s2_valid;
  logic [6:0]        s1_op, s1_f7;
  logic [4:0]        s1_rd, s1_rs1, s1_rs2;
  logic [2:0]        s1_f3;
  logic [31:0]       s1_imm;
  logic [31:0]       s2_instr;
  logic              s2_err;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        err_cnt;

  logic        s1_adv, s2_adv, out_xfer;
  fmt_t        fmt;
  logic        shift;
  logic [31:0] imm_bits;
  logic        imm_err;
  logic [31:0] word;
  logic        word_err;

  assign s2_adv   = !s2_valid || iReady;
  assign s1_adv   = !s1_valid || s2_adv;
  assign oReady   = s1_adv && !iClear;
  assign out_xfer = s2_valid && iReady;

  assign fmt   = fmt_of(s1_op);
  assign shift = (s1_op == OP_IMM) && (s1_f3 == 3'b001 || s1_f3 == 3'b101);

  imm_pack u_imm_pack (
    .fmt    (fmt),
    .imm    (s1_imm),
    .shift  (shift),
    .placed (imm_bits),
    .err    (imm_err)
  );

  always_comb begin
    word     = NOP;
    word_err = 1'b1;
    case (fmt)
      FMT_R: begin
        word     = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
        word_err = 1'b0;
      end
      FMT_I: begin
        word     = imm_bits | {12'b0, s1_rs1, s1_f3, s1_rd, s1_op}
                 | (shift ? {s1_f7, 25'b0} : 32'b0);
        word_err = imm_err;
      end
      FMT_S, FMT_B: begin
        word     = imm_bits | {7'b0, s1_rs2, s1_rs1, s1_f3, 5'b0, s1_op};
        word_err = imm_err;
      end
      FMT_U, FMT_J: begin
        word     = imm_bits | {20'b0, s1_rd, s1_op};
        word_err = imm_err;
      end
      default: begin
        word     = NOP;
        word_err = 1'b1;
      end
    endcase
  end

  // Input field capture needs no reset: s1_valid qualifies it.
  always_ff @(posedge iClk) begin
    if (iValid && oReady) begin
      s1_op  <= iOpcode;
      s1_rd  <= iRd;
      s1_f3  <= iFunct3;
      s1_rs1 <= iRs1;
      s1_rs2 <= iRs2;
      s1_f7  <= iFunct7;
      s1_imm <= iImm;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= 32'b0;
      s2_err   <= 1'b0;
      addr     <= BASE;
      err_cnt  <= 8'd0;
    end else if (iClear) begin
      // A transfer on this cycle is discarded, so neither counter advances.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      addr     <= BASE;
    end else begin
      if (s1_adv) s1_valid <= iValid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_instr <= word;
        s2_err   <= word_err;
      end
      if (out_xfer) begin
        addr <= addr + ADDR_W'(1);
        if (s2_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign oValid  = s2_valid;
  assign oInstr  = s2_instr;
  assign oErr    = s2_err;
  assign oAddr   = addr;
  assign oErrCnt = err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with a narrow-address twin instance.
// Rev 1.0
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm;

  logic        ready, valid, err;
  logic [31:0] instr;
  logic [9:0]  addr;
  logic [7:0]  err_cnt;

  logic        ready2, valid2, err2;
  logic [31:0] instr2;
  logic [1:0]  addr2;
  logic [7:0]  err_cnt2;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          model_addr = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .iClk(clk), .iRst(rst), .iClear(clr), .iValid(in_valid), .oReady(ready),
    .iOpcode(op), .iRd(rd), .iFunct3(f3), .iRs1(rs1), .iRs2(rs2), .iFunct7(f7), .iImm(imm),
    .oValid(valid), .iReady(out_ready), .oInstr(instr), .oAddr(addr), .oErr(err),
    .oErrCnt(err_cnt)
  );

  // Same stimulus, 2-bit counter based at 2: exercises wrap and non-zero reload.
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut2 (
    .iClk(clk), .iRst(rst), .iClear(clr), .iValid(in_valid), .oReady(ready2),
    .iOpcode(op), .iRd(rd), .iFunct3(f3), .iRs1(rs1), .iRs2(rs2), .iFunct7(f7), .iImm(imm),
    .oValid(valid2), .iReady(out_ready), .oInstr(instr2), .oAddr(addr2), .oErr(err2),
    .oErrCnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output transfer, check hold under backpressure.
  initial begin
    exp_t        e;
    logic        held = 1'b0;
    logic [31:0] h_instr;
    logic [9:0]  h_addr;
    logic        h_err;
    forever begin
      @(negedge clk);
      if (held && valid) begin
        chk("hold_instr", instr, h_instr);
        chk("hold_addr", {22'b0, addr}, {22'b0, h_addr});
        chk("hold_err", {31'b0, err}, {31'b0, h_err});
      end
      if (valid && out_ready && !clr && !rst) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", instr, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("instr", instr, e.instr);
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("addr", {22'b0, addr}, model_addr);
          chk("addr_w2", {30'b0, addr2}, (model_addr + 2) % 4);
          chk("valid_w2", {31'b0, valid2}, 32'd1);
          model_addr++;
        end
      end
      held    = valid && !out_ready && !clr && !rst;
      h_instr = instr;
      h_addr  = addr;
      h_err   = err;
    end
  end

  task automatic present(input logic [6:0] o, input logic [4:0] d, input logic [2:0] fn3,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] fn7,
                         input logic [31:0] im);
    op = o; rd = d; f3 = fn3; rs1 = s1; rs2 = s2; f7 = fn7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic accept(input logic [31:0] ei, input logic ee);
    int n = 0;
    logic ok = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    if (ok) sb.push_back('{instr: ei, err: ee});
    else chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [2:0] fn3,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] fn7,
                      input logic [31:0] im, input logic [31:0] ei, input logic ee);
    present(o, d, fn3, s1, s2, fn7, im);
    accept(ei, ee);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rd = '0; f3 = '0; rs1 = '0; rs2 = '0; f7 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_addr", {22'b0, addr}, 32'd0);
    chk("rst_addr_w2", {30'b0, addr2}, 32'd2);
    chk("rst_errcnt", {24'b0, err_cnt}, 32'd0);
    @(posedge clk); #1;

    // Legal encodings, streamed back-to-back
    send(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0,         32'h002081B3, 1'b0); // add
    send(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0); // addi -1
    send(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd8,         32'h00208463, 1'b0); // beq +8
    send(7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd2048,      32'h001000EF, 1'b0); // jal +2048
    send(7'b0100011, 5'd0, 3'b010, 5'd2, 5'd5, 7'd0, 32'hFFFF_FFFC, 32'hFE512E23, 1'b0); // sw -4
    send(7'b0110111, 5'd5, 3'b000, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 32'h123452B7, 1'b0); // lui
    send(7'b0010011, 5'd3, 3'b101, 5'd4, 5'd0, 7'b0100000, 32'd7,   32'h40725193, 1'b0); // srai 7
    drain();
    chk("errcnt_clean", {24'b0, err_cnt}, 32'd0);

    // Encoding errors still emit a truncated word
    send(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd5,    32'h00208263, 1'b1); // beq odd
    send(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1); // addi 2048
    send(7'b0000000, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd0,    32'h00000013, 1'b1); // bad opcode
    drain();
    chk("errcnt_3", {24'b0, err_cnt}, 32'd3);
    send(7'b0010011, 5'd1, 3'b001, 5'd1, 5'd0, 7'd0, 32'd32,     32'h00009093, 1'b1); // slli 32
    send(7'b0010111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'h1001,   32'h00001097, 1'b1); // auipc low bits
    drain();
    chk("errcnt_5", {24'b0, err_cnt}, 32'd5);

    // Backpressure: two words fill the pipe, the third is refused until release
    out_ready = 1'b0;
    send(7'b0110011, 5'd4, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h00208233, 1'b0);
    send(7'b0110011, 5'd5, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002082B3, 1'b0);
    present(7'b0110011, 5'd6, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", {31'b0, ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    accept(32'h00208333, 1'b0);
    drain();

    // Clear with two words in flight; the errored head transfer is discarded
    out_ready = 1'b0;
    send(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd5, 32'h00208263, 1'b1);
    send(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3, 1'b0);
    clr = 1'b1;
    out_ready = 1'b1;
    present(7'b0110011, 5'd7, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0);
    @(negedge clk);
    chk("clr_ready", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_addr = 0;
    @(negedge clk);
    chk("clr_valid", {31'b0, valid}, 32'd0);
    chk("clr_addr", {22'b0, addr}, 32'd0);
    chk("clr_addr_w2", {30'b0, addr2}, 32'd2);
    chk("clr_errcnt", {24'b0, err_cnt}, 32'd5);
    @(negedge clk);
    chk("clr_no_accept", {31'b0, valid}, 32'd0);
    @(posedge clk); #1;
    send(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3, 1'b0);
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    send(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd5, 32'h00208263, 1'b1);
    send(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    model_addr = 0;
    @(negedge clk);
    chk("rst2_valid", {31'b0, valid}, 32'd0);
    chk("rst2_instr", instr, 32'd0);
    chk("rst2_err", {31'b0, err}, 32'd0);
    chk("rst2_addr", {22'b0, addr}, 32'd0);
    chk("rst2_errcnt", {24'b0, err_cnt}, 32'd0);
    chk("rst2_ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    send(7'b0100011, 5'd0, 3'b010, 5'd2, 5'd5, 7'd0, 32'hFFFF_FFFC, 32'hFE512E23, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
